// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// ram_fifo_ctrl
// ----------------------------------------------------------------------------
// Purpose
//   Controller for a 17-entry byte FIFO. Sixteen entries live in an external
//   16x8 dual-port RAM. The seventeenth entry is the output register that
//   presents the oldest byte on rd_data.
//
//   The RAM has a registered read with one cycle of latency. Draining an entry
//   from the RAM into the output register therefore takes two steps:
//     FETCH : the read address was presented on the previous edge, and the
//             RAM output register is loading the byte.
//     HOLD  : the byte sits in rd_data with rd_valid high until it is popped.
//   Because of this, a sustained pop rate is one entry every two cycles.
//
// Configuration
//   RAMFIFO_LEVEL_EN : when defined, the design adds the level and
//                      almost_full ports and the logic that drives them.
//                      When undefined, those ports and that logic are absent.
//
// Parameters
//   AFULL_THRESH : level (in entries) at which almost_full asserts.
//
// Ports
//   clk          : single clock; all state changes on its rising edge.
//   rst_n        : asynchronous, active-low reset.
//   wr_valid     : push request.
//   wr_data[7:0] : byte to push.
//   wr_ready     : the push is taken when wr_valid & wr_ready.
//   rd_valid     : rd_data holds the oldest entry.
//   rd_data[7:0] : byte to pop.
//   rd_ready     : the pop is taken when rd_valid & rd_ready.
//   ram_addr_a   : RAM port A (write) address.
//   ram_we_a     : RAM port A write enable.
//   ram_din_a    : RAM port A write data.
//   ram_addr_b   : RAM port B (read) address.
//   ram_we_b     : RAM port B write enable; always 0.
//   ram_din_b    : RAM port B write data; always 0.
//   ram_dout_b   : RAM port B read data; registered, one-cycle latency.
//   level[4:0]   : total entries held, 0..17       (RAMFIFO_LEVEL_EN only).
//   almost_full  : level >= AFULL_THRESH            (RAMFIFO_LEVEL_EN only).
//
// At system level, the RAM's own reset input is driven by ~rst_n. A reset in
// the middle of a read therefore also clears the RAM output register.
// ============================================================================
module ram_fifo_ctrl #(
    parameter int AFULL_THRESH = 14
) (
    input  logic       clk,
    input  logic       rst_n,

    // push side
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,

    // pop side
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,

    // RAM write port A
    output logic [3:0] ram_addr_a,
    output logic       ram_we_a,
    output logic [7:0] ram_din_a,

    // RAM read port B
    output logic [3:0] ram_addr_b,
    output logic       ram_we_b,
    output logic [7:0] ram_din_b,
    input  logic [7:0] ram_dout_b
`ifdef RAMFIFO_LEVEL_EN
    ,
    output logic [4:0] level,
    output logic       almost_full
`endif
);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // output register empty, no read in flight
        FETCH = 2'd1,   // read issued last edge, RAM data arrives this cycle
        HOLD  = 2'd2    // output register holds a valid entry
    } state_t;

    localparam logic [4:0] RAM_DEPTH = 5'd16;

    state_t     state_reg;
    state_t     state_next;

    logic [3:0] wr_ptr_reg;
    logic [3:0] wr_ptr_next;
    logic [3:0] rd_ptr_reg;
    logic [3:0] rd_ptr_next;
    logic [4:0] ram_cnt_reg;    // written to RAM but not yet fetched, 0..16
    logic [4:0] ram_cnt_next;
    logic [7:0] rd_data_reg;
    logic [7:0] rd_data_next;

    logic       push;           // accepted write this cycle
    logic       pop;            // accepted read this cycle
    logic       fetch;          // RAM read issued this cycle
    logic       ram_has_data;

    // ------------------------------------------------------------------------
    // Push side
    // ------------------------------------------------------------------------
    // wr_ready depends only on the RAM occupancy. The output register is
    // refilled from the RAM, never directly from wr_data. This keeps every
    // write going through port A.
    assign wr_ready     = (ram_cnt_reg != RAM_DEPTH);
    assign ram_has_data = (ram_cnt_reg != 5'd0);

    // rst_n gates the push so that the RAM sees no write while reset is
    // asserted, even if wr_valid happens to be high at that time.
    assign push = wr_valid & wr_ready & rst_n;
    assign pop  = rd_valid & rd_ready;

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr_reg;
    assign ram_din_a  = wr_data;

    // Port B is used for reads only.
    assign ram_we_b  = 1'b0;
    assign ram_din_b = 8'h00;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (ram_has_data) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // The RAM data is captured into rd_data at this edge.
                state_next = HOLD;
            end
            HOLD: begin
                if (pop) begin
                    state_next = ram_has_data ? FETCH : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // A read is issued only when the output register is empty (IDLE), or when
    // it is being vacated this cycle (HOLD with a pop). In HOLD, the state
    // itself already implies rd_valid, so the fetch condition uses rd_ready.
    // A fetch never hits the slot being written in the same cycle: a fetch
    // needs ram_cnt > 0, so rd_ptr != wr_ptr unless the RAM is full, and a
    // full RAM accepts no push.
    always_comb begin
        rd_valid   = 1'b0;
        fetch      = 1'b0;
        ram_addr_b = rd_ptr_reg;    // a read with no fetch is harmless
        unique case (state_reg)
            IDLE: begin
                fetch = ram_has_data;
            end
            FETCH: begin
                fetch = 1'b0;
            end
            HOLD: begin
                rd_valid = 1'b1;
                fetch    = ram_has_data & rd_ready;
            end
            default: begin
                rd_valid = 1'b0;
                fetch    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: pointers, occupancy and output register
    // ------------------------------------------------------------------------
    // The 4-bit pointers wrap from 15 to 0 on their own.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        ram_cnt_next = ram_cnt_reg;
        rd_data_next = rd_data_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 4'd1;
        end
        if (fetch) begin
            rd_ptr_next = rd_ptr_reg + 4'd1;
        end

        // A push and a fetch in the same cycle cancel out.
        unique case ({push, fetch})
            2'b10:   ram_cnt_next = ram_cnt_reg + 5'd1;
            2'b01:   ram_cnt_next = ram_cnt_reg - 5'd1;
            default: ram_cnt_next = ram_cnt_reg;
        endcase

        // The output register loads only on the FETCH->HOLD edge. In HOLD it
        // stays stable until the entry is popped.
        if (state_reg == FETCH) begin
            rd_data_next = ram_dout_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= 4'd0;
            rd_ptr_reg  <= 4'd0;
            ram_cnt_reg <= 5'd0;
            rd_data_reg <= 8'h00;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            ram_cnt_reg <= ram_cnt_next;
            rd_data_reg <= rd_data_next;
        end
    end

    assign rd_data = rd_data_reg;

    // ------------------------------------------------------------------------
    // Optional occupancy reporting
    // ------------------------------------------------------------------------
`ifdef RAMFIFO_LEVEL_EN
    // A non-IDLE state means one entry is either in flight from the RAM or
    // held in the output register. Either way, it still counts as held.
    localparam logic [4:0] AFULL_LVL = 5'(AFULL_THRESH);

    logic out_busy;

    assign out_busy    = (state_reg != IDLE);
    assign level       = ram_cnt_reg + {4'd0, out_busy};
    assign almost_full = (level >= AFULL_LVL);
`else
    // The threshold only matters when occupancy reporting is built in.
    logic [4:0] unused_afull_thresh;
    assign unused_afull_thresh = 5'(AFULL_THRESH);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [3:0] ram_addr_a;
    logic       ram_we_a;
    logic [7:0] ram_din_a;
    logic [3:0] ram_addr_b;
    logic       ram_we_b;
    logic [7:0] ram_din_b;
    logic [7:0] ram_dout_b;
`ifdef RAMFIFO_LEVEL_EN
    logic [4:0] level;
    logic       almost_full;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    ram_fifo_ctrl #(.AFULL_THRESH(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .ram_addr_a (ram_addr_a),
        .ram_we_a   (ram_we_a),
        .ram_din_a  (ram_din_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
`ifdef RAMFIFO_LEVEL_EN
        ,
        .level      (level),
        .almost_full(almost_full)
`endif
    );

    // 16x8 dual-port RAM with registered read; its reset is driven by ~rst_n
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_dout_b <= 8'h00;
        else        ram_dout_b <= mem[ram_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Scoreboard monitor: every pop handshake is compared with the oldest
    // expected byte.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%02h required=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                pops++;
                check("pop_data", {24'd0, rd_data}, {24'd0, mon_exp});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=wr_ready_low required=accept data=%02h", d);
        end else begin
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int pops_before;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_rd_valid", {31'd0, rd_valid}, 0);
        check("rst_rd_data", {24'd0, rd_data}, 0);
        check("rst_ram_we_a", {31'd0, ram_we_a}, 0);
        check("rst_wr_ready", {31'd0, wr_ready}, 1);
        check("ram_we_b_tied", {31'd0, ram_we_b}, 0);
        check("ram_din_b_tied", {24'd0, ram_din_b}, 0);
`ifdef RAMFIFO_LEVEL_EN
        check("rst_level", {27'd0, level}, 0);
        check("rst_afull", {31'd0, almost_full}, 0);
`endif
        repeat (2) @(posedge clk);

        // ---- single push 0xA5 on the first edge after release ----
        @(negedge clk);
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        #1;
        check("first_we_a", {31'd0, ram_we_a}, 1);
        check("first_addr_a", {28'd0, ram_addr_a}, 0);
        check("first_din_a", {24'd0, ram_din_a}, 32'hA5);
        check("first_wr_ready", {31'd0, wr_ready}, 1);
        exp_q.push_back(8'hA5);
        tick();
        wr_valid = 1'b0;
        check("lat0_rd_valid", {31'd0, rd_valid}, 0);
        check("lat0_addr_b", {28'd0, ram_addr_b}, 0);
        tick();
        check("lat1_rd_valid", {31'd0, rd_valid}, 0);
        tick();
        check("lat2_rd_valid", {31'd0, rd_valid}, 1);
        check("lat2_rd_data", {24'd0, rd_data}, 32'hA5);
`ifdef RAMFIFO_LEVEL_EN
        check("single_level", {27'd0, level}, 1);
`endif
        tick();
        check("hold_rd_valid", {31'd0, rd_valid}, 1);
        check("hold_rd_data", {24'd0, rd_data}, 32'hA5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("single_popped", {31'd0, rd_valid}, 0);
        check("single_addr_b", {28'd0, ram_addr_b}, 1);

        // ---- fill with 17 entries 0x00..0x10 ----
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            check("fill_wr_ready", {31'd0, wr_ready}, {31'd0, (i != 16)});
`ifdef RAMFIFO_LEVEL_EN
            check("fill_level", {27'd0, level}, i + 1);
            check("fill_afull", {31'd0, almost_full}, {31'd0, (i + 1 >= 14)});
`endif
        end

        // a push attempt while full must be refused
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        @(negedge clk);
        check("full_wr_ready", {31'd0, wr_ready}, 0);
        tick();
        wr_valid = 1'b0;

        // ---- push and pop in the same cycle at ram_cnt=16 ----
        wr_valid = 1'b1;
        wr_data  = 8'h11;
        rd_ready = 1'b1;
        @(negedge clk);
        check("pushpop_wr_ready", {31'd0, wr_ready}, 0);
        check("pushpop_rd_valid", {31'd0, rd_valid}, 1);
        tick();
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        check("after_fetch_wr_ready", {31'd0, wr_ready}, 1);
        push(8'h11);
`ifdef RAMFIFO_LEVEL_EN
        check("refill_level", {27'd0, level}, 17);
`endif

        // ---- drain: rd_valid must alternate 1/0 ----
        rd_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("drain_valid", {31'd0, rd_valid}, 1);
            @(negedge clk);
            check("drain_gap", {31'd0, rd_valid}, 0);
        end
        tick();
        rd_ready = 1'b0;
        check("drained_rd_valid", {31'd0, rd_valid}, 0);
        check("drained_queue", exp_q.size(), 0);
        check("drained_wr_ready", {31'd0, wr_ready}, 1);
`ifdef RAMFIFO_LEVEL_EN
        check("drained_level", {27'd0, level}, 0);
`endif

        // ---- 40 counter pushes with concurrent pops ----
        pops_before = pops;
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(8'h80 + 8'(i));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check("stream_drained", exp_q.size(), 0);
        check("stream_pops", pops - pops_before, 40);
        tick();
        check("stream_idle", {31'd0, rd_valid}, 0);

        // ---- reset while in FETCH with 5 entries ----
        for (int i = 0; i < 6; i++) begin
            push(8'h50 + 8'(i));
        end
`ifdef RAMFIFO_LEVEL_EN
        check("pre_level", {27'd0, level}, 6);
`endif
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("fetch_rd_valid", {31'd0, rd_valid}, 0);
`ifdef RAMFIFO_LEVEL_EN
        check("fetch_level", {27'd0, level}, 5);
`endif
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_rd_valid", {31'd0, rd_valid}, 0);
        check("midrst_rd_data", {24'd0, rd_data}, 0);
        check("midrst_wr_ready", {31'd0, wr_ready}, 1);
`ifdef RAMFIFO_LEVEL_EN
        check("midrst_level", {27'd0, level}, 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push(8'h3C);
        tick();
        tick();
        check("post_rst_rd_valid", {31'd0, rd_valid}, 1);
        check("post_rst_rd_data", {24'd0, rd_data}, 32'h3C);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("post_rst_queue", exp_q.size(), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
